// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FIFO word type and frame check for the PS/2 receiver
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  // One decoded key event as stored in the receive FIFO
  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } ps2_key_t;

  // Frame assembly state: idle waits for the start bit, frame collects bits 1..10
  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_FRAME = 1'b1
  } ps2_rx_state_t;

  // Frame layout: [0] start, [8:1] data LSB first, [9] parity, [10] stop
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && ((^f[9:1]) == 1'b1) && (f[10] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module ps2_sync_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_valid_i,
  input  T                       wr_data_i,
  input  logic                   rd_ready_i,
  output T                       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  // Head is forced to zero when empty so the outputs read as cleared after reset
  assign rd_data_o = empty_o ? T'('0) : mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    pop      = rd_ready_i && !empty_o;
    push     = wr_valid_i && (!full_o || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, cleared on reset so no stale entry can ever surface
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= T'('0);
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - filtered PS/2 receiver with framing check, prefix decode and FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int DEPTH          = 16,
  parameter int PREFIX_DECODE  = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_code,
  output logic                   out_extended,
  output logic                   out_break,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   frame_error,
  output logic                   overflow,
  input  logic                   err_clear
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      FCNT_MAX  = 4'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [3:0]      LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  // Line index 0 is the PS/2 clock, index 1 is the PS/2 data
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic            clk_prev_q;
  logic            fall_w;

  ps2_rx_state_t   state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      sr_q, sr_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;
  logic            frame_err_q, frame_err_d;
  logic            frame_abort;
  logic [PS2_FRAME_BITS-1:0] frame_w;

  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            overflow_q, overflow_d;
  logic            is_ext, is_brk;
  logic            push_w, pop_w, drop_w;
  ps2_key_t        push_key, head;
  logic            fifo_full, fifo_empty;

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {ps2_dat, ps2_clk};
      sync2_q <= sync1_q;
    end
  end

  // Glitch filter: a line flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCNT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Filtered line state and previous clock level for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= 2'b11;
      fcnt_q     <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  assign fall_w  = clk_prev_q && !filt_q[0];
  assign frame_w = {filt_q[1], sr_q};

  // Frame FSM next state: shift bits on filtered falling edges, check at the stop bit, time out stalls
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    to_cnt_d    = to_cnt_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_w) begin
          state_d   = RX_FRAME;
          bit_cnt_d = 4'd1;
          sr_d      = {filt_q[1], sr_q[9:1]};
          to_cnt_d  = TO_RELOAD;
        end
      end
      RX_FRAME: begin
        if (fall_w) begin
          to_cnt_d = TO_RELOAD;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = RX_IDLE;
            bit_cnt_d = 4'd0;
            if (ps2_frame_ok(frame_w)) begin
              byte_vld_d = 1'b1;
              byte_d     = frame_w[8:1];
            end else begin
              frame_err_d = 1'b1;
              frame_abort = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sr_d      = {filt_q[1], sr_q[9:1]};
          end
        end else if (to_cnt_q == '0) begin
          state_d     = RX_IDLE;
          bit_cnt_d   = 4'd0;
          frame_err_d = 1'b1;
          frame_abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - TO_ONE;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // Frame FSM registers, including the one-cycle byte strobe and error pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 4'd0;
      sr_q        <= '0;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      to_cnt_q    <= to_cnt_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Prefix decoder: E0/F0 only set flags, any other byte is pushed with the flags and clears them
  always_comb begin
    is_ext   = (PREFIX_DECODE != 0) && (byte_q == PS2_PREFIX_EXT);
    is_brk   = (PREFIX_DECODE != 0) && (byte_q == PS2_PREFIX_BRK);
    push_w   = byte_vld_q && !is_ext && !is_brk;
    push_key = '{extended: ext_q, brk: brk_q, code: byte_q};
    pop_w    = out_valid && out_ready;
    drop_w   = push_w && fifo_full && !pop_w;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (frame_abort) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (is_ext) begin
        ext_d = 1'b1;
      end else if (is_brk) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    overflow_d = overflow_q;
    if (drop_w) begin
      overflow_d = 1'b1;
    end else if (err_clear) begin
      overflow_d = 1'b0;
    end
  end

  // Prefix flags and sticky overflow; a same-cycle drop beats err_clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (ps2_key_t)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .wr_valid_i (push_w),
    .wr_data_i  (push_key),
    .rd_ready_i (out_ready),
    .rd_data_o  (head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_code     = head.code;
  assign out_extended = head.extended;
  assign out_break    = head.brk;
  assign frame_error  = frame_err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 16384;
  localparam int DEPTH = 16;
  localparam int HALF  = 20;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   ps2_clk = 1'b1;
  logic                   ps2_dat = 1'b1;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [7:0]             out_code;
  logic                   out_extended;
  logic                   out_break;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   frame_error;
  logic                   overflow;
  logic                   err_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int ferr_cnt = 0;
  logic [9:0] sb[$];

  ps2_rx_fifo #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .DEPTH          (DEPTH),
    .PREFIX_DECODE  (1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_extended (out_extended),
    .out_break    (out_break),
    .fifo_count   (fifo_count),
    .frame_error  (frame_error),
    .overflow     (overflow),
    .err_clear    (err_clear)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_error === 1'b1) ferr_cnt++;
  end

  initial begin
    repeat (150000) @(posedge clock);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                            input int gclk_bit, input int gdat_bit, input int nbits);
    logic [10:0] f;
    f = {stop_v, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      if (i == gclk_bit) begin
        wait_clk(5); ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; wait_clk(HALF - 8);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      if (i == gdat_bit) begin
        wait_clk(5); ps2_dat = ~f[i]; wait_clk(1); ps2_dat = f[i]; wait_clk(HALF - 6);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] d, input logic exp_push, input logic [1:0] flags);
    if (exp_push) sb.push_back({flags, d});
    send_frame(d, 1'b0, 1'b1, -1, -1, 11);
    wait_clk(FL + 6);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] want;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 2000) begin
      wait_clk(1);
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) want = 10'h3FF;
    else want = sb.pop_front();
    check(tag, {22'd0, out_extended, out_break, out_code}, {22'd0, want});
    out_ready = 1'b1;
    wait_clk(1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int base;

    // Reset state
    wait_clk(4);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_code", {24'd0, out_code}, 32'd0);
    check("rst_flags", {30'd0, out_extended, out_break}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_ferr", {31'd0, frame_error}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    // 1: latency of a clean 0x1C frame
    sb.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, -1, -1, 10);
    ps2_dat = 1'b1;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      wait_clk(1);
      lat++;
    end
    check("t1_latency", lat, FL + 4);
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF);
    pop_check("t1_head");
    check("t1_empty", {31'd0, out_valid}, 32'd0);

    // 2: prefix folding
    good_frame(8'hE0, 1'b0, 2'b00);
    good_frame(8'hF0, 1'b0, 2'b00);
    good_frame(8'h75, 1'b1, 2'b11);
    check("t2_count", {27'd0, fifo_count}, 32'd1);
    pop_check("t2_ext_brk");
    good_frame(8'h75, 1'b1, 2'b00);
    pop_check("t2_plain");

    // 3: bad parity then bad stop
    base = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1, -1, 11);
    wait_clk(FL + 6);
    check("t3_par_ferr", ferr_cnt - base, 32'd1);
    check("t3_par_count", {27'd0, fifo_count}, 32'd0);
    base = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, -1, -1, 11);
    wait_clk(FL + 6);
    check("t3_stop_ferr", ferr_cnt - base, 32'd1);
    check("t3_stop_count", {27'd0, fifo_count}, 32'd0);

    // 4: timeout after a partial frame, then recovery
    base = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b1, -1, -1, 5);
    wait_clk(TO + 10);
    check("t4_timeout_ferr", ferr_cnt - base, 32'd1);
    good_frame(8'h29, 1'b1, 2'b00);
    check("t4_recover_ferr", ferr_cnt - base, 32'd1);
    pop_check("t4_head");

    // 5: overflow with consumer stalled
    for (int i = 1; i <= DEPTH + 2; i++) begin
      good_frame(8'(i), (i <= DEPTH) ? 1'b1 : 1'b0, 2'b00);
      if (i == DEPTH) check("t5_ovf_before", {31'd0, overflow}, 32'd0);
    end
    check("t5_count_full", {27'd0, fifo_count}, DEPTH);
    check("t5_ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) pop_check($sformatf("t5_drain%0d", i));
    check("t5_count_empty", {27'd0, fifo_count}, 32'd0);
    check("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    err_clear = 1'b1;
    wait_clk(1);
    err_clear = 1'b0;
    check("t5_ovf_clear", {31'd0, overflow}, 32'd0);

    // 6: glitches on both lines do not disturb the byte
    base = ferr_cnt;
    sb.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, 4, 6, 11);
    wait_clk(FL + 6);
    check("t6_glitch_count", {27'd0, fifo_count}, 32'd1);
    pop_check("t6_glitch_head");
    check("t6_glitch_ferr", ferr_cnt - base, 32'd0);

    // 6: asynchronous reset mid-frame discards FIFO and partial frame
    send_frame(8'h33, 1'b0, 1'b1, -1, -1, 11);
    wait_clk(FL + 6);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    send_frame(8'h44, 1'b0, 1'b1, -1, -1, 4);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_count", {27'd0, fifo_count}, 32'd0);
    check("t6_async_code", {24'd0, out_code}, 32'd0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    base = ferr_cnt;
    good_frame(8'h6B, 1'b1, 2'b00);
    check("t6_post_count", {27'd0, fifo_count}, 32'd1);
    pop_check("t6_post_head");
    check("t6_post_ferr", ferr_cnt - base, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
